// File: rtl/bus_slave_if_pkg.sv
// Shared bus definitions for slave-side responders: polarity constants, bus widths
// and the responder state encoding.
package bus_slave_if_pkg;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int WordAddrBus    = 30;
    localparam int WordDataBus    = 32;
    localparam int BusSlvStateBus = 2;

    typedef enum logic [BusSlvStateBus-1:0] {
        BUS_SLV_STATE_IDLE  = 2'd0,
        BUS_SLV_STATE_WAIT  = 2'd1,
        BUS_SLV_STATE_DEV   = 2'd2,
        BUS_SLV_STATE_READY = 2'd3
    } bus_slv_state_e;

    // A master access targets this slave only when both active-low strobes are low.
    function automatic logic bus_select(input logic cs_n, input logic as_n);
        return (cs_n == ENABLE_) && (as_n == ENABLE_);
    endfunction

endpackage

// File: rtl/bus_slv_downcnt.sv
// Loadable 8-bit down-counter with a zero flag; load wins over decrement and the
// count holds at zero instead of wrapping.
module bus_slv_downcnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [7:0] cnt,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == 8'd0);

endmodule

// File: rtl/bus_slave_if.sv
// Bus-side responder for one slave device: latches a selected access, inserts wait
// states, handshakes with the device, then returns a one-cycle ready with read data.
// Optional device-ack timeout is enabled with `define BUS_SLAVE_TIMEOUT_EN.
module bus_slave_if
    import bus_slave_if_pkg::*;
#(
    parameter int ADDR_W      = WordAddrBus,
    parameter int DATA_W      = WordDataBus,
    parameter int WAIT_CYCLES = 1,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rdy_,
    output logic              dev_req,
    output logic              dev_rw,
    output logic [ADDR_W-1:0] dev_addr,
    output logic [DATA_W-1:0] dev_wr_data,
    input  logic [DATA_W-1:0] dev_rd_data,
    input  logic              dev_ack,
    output logic              err
);

    localparam logic [7:0] WAIT_VAL    = 8'(WAIT_CYCLES);
    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

    bus_slv_state_e    state;
    logic [DATA_W-1:0] rd_buf;

    logic       accept;
    logic       wait_load;
    logic       wait_dec;
    logic       wait_done;
    logic       dev_enter;
    logic [7:0] wait_cnt;
    logic       wait_zero;
    logic       to_expired;

    // Requests arriving outside IDLE are protocol violations and simply never accepted.
    assign accept    = (state == BUS_SLV_STATE_IDLE) && bus_select(cs_, as_);
    assign wait_load = accept && (WAIT_VAL != 8'd0);
    assign wait_dec  = (state == BUS_SLV_STATE_WAIT);
    assign wait_done = wait_dec && ((wait_cnt == 8'd1) || wait_zero);
    assign dev_enter = (accept && (WAIT_VAL == 8'd0)) || wait_done;

    bus_slv_downcnt u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (wait_load),
        .load_val (WAIT_VAL),
        .dec      (wait_dec),
        .cnt      (wait_cnt),
        .zero     (wait_zero)
    );

`ifdef BUS_SLAVE_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       to_zero;
    logic       to_dec;

    // Expiry is judged only on cycles without dev_ack, so a same-cycle ack completes normally.
    assign to_dec     = (state == BUS_SLV_STATE_DEV) && !dev_ack;
    assign to_expired = to_dec && ((to_cnt == 8'd1) || to_zero);

    bus_slv_downcnt u_timeout_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (dev_enter),
        .load_val (TIMEOUT_VAL),
        .dec      (to_dec),
        .cnt      (to_cnt),
        .zero     (to_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else begin
            err <= to_expired;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_VAL;
    assign to_expired     = 1'b0;
    assign err            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BUS_SLV_STATE_IDLE;
            rdy_        <= DISABLE_;
            dev_req     <= 1'b0;
            dev_rw      <= READ;
            dev_addr    <= '0;
            dev_wr_data <= '0;
            rd_buf      <= '0;
        end else begin
            rdy_ <= DISABLE_;
            case (state)
                BUS_SLV_STATE_IDLE: begin
                    if (accept) begin
                        dev_rw      <= rw;
                        dev_addr    <= addr;
                        dev_wr_data <= wr_data;
                        dev_req     <= dev_enter;
                        state       <= dev_enter ? BUS_SLV_STATE_DEV : BUS_SLV_STATE_WAIT;
                    end
                end
                BUS_SLV_STATE_WAIT: begin
                    if (wait_done) begin
                        dev_req <= 1'b1;
                        state   <= BUS_SLV_STATE_DEV;
                    end
                end
                BUS_SLV_STATE_DEV: begin
                    if (dev_ack) begin
                        if (dev_rw == READ) begin
                            rd_buf <= dev_rd_data;
                        end
                        dev_req <= 1'b0;
                        rdy_    <= ENABLE_;
                        state   <= BUS_SLV_STATE_READY;
                    end else if (to_expired) begin
                        rd_buf  <= '0;
                        dev_req <= 1'b0;
                        rdy_    <= ENABLE_;
                        state   <= BUS_SLV_STATE_READY;
                    end
                end
                BUS_SLV_STATE_READY: begin
                    dev_rw      <= READ;
                    dev_addr    <= '0;
                    dev_wr_data <= '0;
                    state       <= BUS_SLV_STATE_IDLE;
                end
                default: begin
                    state <= BUS_SLV_STATE_IDLE;
                end
            endcase
        end
    end

    // Zero outside READY lets several slaves share an OR-combined read bus.
    assign rd_data = ((state == BUS_SLV_STATE_READY) && (dev_rw == READ)) ? rd_buf : '0;

endmodule

// File: tb/tb_bus_slave_if.sv
// Directed bench for bus_slave_if: instance A runs two wait states, instance B none;
// with BUS_SLAVE_TIMEOUT_EN defined the ack-timeout path is exercised on A.
module tb_bus_slave_if;
    import bus_slave_if_pkg::*;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs_a, cs_b, as_, rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data, dev_rd_data;
    logic          dev_ack_a, dev_ack_b;

    logic [DW-1:0] rd_data_a, rd_data_b, dev_wr_data_a, dev_wr_data_b;
    logic [AW-1:0] dev_addr_a, dev_addr_b;
    logic          rdy_a, rdy_b, dev_req_a, dev_req_b, dev_rw_a, dev_rw_b, err_a, err_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bus_slave_if #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2), .TIMEOUT(4)) u_dut_a (
        .clk(clk), .reset(reset), .cs_(cs_a), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data_a), .rdy_(rdy_a), .dev_req(dev_req_a),
        .dev_rw(dev_rw_a), .dev_addr(dev_addr_a), .dev_wr_data(dev_wr_data_a),
        .dev_rd_data(dev_rd_data), .dev_ack(dev_ack_a), .err(err_a)
    );

    bus_slave_if #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .reset(reset), .cs_(cs_b), .as_(as_), .rw(rw), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data_b), .rdy_(rdy_b), .dev_req(dev_req_b),
        .dev_rw(dev_rw_b), .dev_addr(dev_addr_b), .dev_wr_data(dev_wr_data_b),
        .dev_rd_data(dev_rd_data), .dev_ack(dev_ack_b), .err(err_b)
    );

    // Each call moves to the next bus cycle; outputs are stable here and inputs are driven here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset = 1'b1; cs_a = 1'b1; cs_b = 1'b1; as_ = 1'b1; rw = READ;
        addr = '0; wr_data = '0; dev_rd_data = '0; dev_ack_a = 1'b0; dev_ack_b = 1'b0;
        next_cycle();
        next_cycle();
        checks++; if (rdy_a !== 1'b1) begin failures++; $display("[TB] FAIL reset_rdy_a got=%b exp=1", rdy_a); end
        checks++; if (rdy_b !== 1'b1) begin failures++; $display("[TB] FAIL reset_rdy_b got=%b exp=1", rdy_b); end
        checks++; if (rd_data_a !== 32'h0) begin failures++; $display("[TB] FAIL reset_rd_data_a got=%h exp=0", rd_data_a); end
        checks++; if (dev_req_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_dev_req_a got=%b exp=0", dev_req_a); end
        checks++; if (dev_rw_a !== READ) begin failures++; $display("[TB] FAIL reset_dev_rw_a got=%b exp=1", dev_rw_a); end
        checks++; if (dev_addr_a !== 30'h0) begin failures++; $display("[TB] FAIL reset_dev_addr_a got=%h exp=0", dev_addr_a); end
        checks++; if (dev_wr_data_b !== 32'h0) begin failures++; $display("[TB] FAIL reset_dev_wr_data_b got=%h exp=0", dev_wr_data_b); end
        checks++; if (err_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_a got=%b exp=0", err_a); end
        reset = 1'b0;
        next_cycle();
    endtask

    // A reads with two wait states while B sees the same strobe deselected.
    task automatic test_read_wait2();
        logic          exp_req, exp_rdy;
        logic [DW-1:0] exp_data;
        $display("[TB] test_read_wait2");
        cs_a = 1'b0; cs_b = 1'b1; as_ = 1'b0; rw = READ; addr = 30'h10;
        dev_ack_a = 1'b1; dev_rd_data = 32'hDEADBEEF;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            if (k == 1) begin cs_a = 1'b1; as_ = 1'b1; end
            exp_req  = (k == 3);
            exp_rdy  = (k == 4) ? ENABLE_ : DISABLE_;
            exp_data = (k == 4) ? 32'hDEADBEEF : 32'h0;
            checks++; if (dev_req_a !== exp_req) begin failures++; $display("[TB] FAIL rd2_dev_req c%0d got=%b exp=%b", k, dev_req_a, exp_req); end
            checks++; if (rdy_a !== exp_rdy) begin failures++; $display("[TB] FAIL rd2_rdy c%0d got=%b exp=%b", k, rdy_a, exp_rdy); end
            checks++; if (rd_data_a !== exp_data) begin failures++; $display("[TB] FAIL rd2_rd_data c%0d got=%h exp=%h", k, rd_data_a, exp_data); end
            checks++; if (dev_req_b !== 1'b0) begin failures++; $display("[TB] FAIL desel_dev_req c%0d got=%b exp=0", k, dev_req_b); end
            checks++; if (rdy_b !== 1'b1) begin failures++; $display("[TB] FAIL desel_rdy c%0d got=%b exp=1", k, rdy_b); end
            if (k == 3) begin
                checks++; if (dev_addr_a !== 30'h10) begin failures++; $display("[TB] FAIL rd2_dev_addr got=%h exp=10", dev_addr_a); end
                checks++; if (dev_rw_a !== READ) begin failures++; $display("[TB] FAIL rd2_dev_rw got=%b exp=1", dev_rw_a); end
            end
        end
        checks++; if (dev_addr_a !== 30'h0) begin failures++; $display("[TB] FAIL rd2_addr_clear got=%h exp=0", dev_addr_a); end
        dev_ack_a = 1'b0;
        next_cycle();
    endtask

    task automatic test_write_wait0();
        logic exp_req, exp_rdy;
        $display("[TB] test_write_wait0");
        cs_a = 1'b1; cs_b = 1'b0; as_ = 1'b0; rw = WRITE; addr = 30'h3;
        wr_data = 32'h12345678; dev_rd_data = 32'hA5A5A5A5; dev_ack_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            if (k == 1) begin cs_b = 1'b1; as_ = 1'b1; wr_data = 32'h0; rw = READ; end
            exp_req = (k <= 4);
            exp_rdy = (k == 5) ? ENABLE_ : DISABLE_;
            checks++; if (dev_req_b !== exp_req) begin failures++; $display("[TB] FAIL wr_dev_req c%0d got=%b exp=%b", k, dev_req_b, exp_req); end
            checks++; if (rdy_b !== exp_rdy) begin failures++; $display("[TB] FAIL wr_rdy c%0d got=%b exp=%b", k, rdy_b, exp_rdy); end
            checks++; if (rd_data_b !== 32'h0) begin failures++; $display("[TB] FAIL wr_rd_data c%0d got=%h exp=0", k, rd_data_b); end
            if (exp_req) begin
                checks++; if (dev_wr_data_b !== 32'h12345678) begin failures++; $display("[TB] FAIL wr_dev_wr_data c%0d got=%h exp=12345678", k, dev_wr_data_b); end
                checks++; if (dev_rw_b !== WRITE) begin failures++; $display("[TB] FAIL wr_dev_rw c%0d got=%b exp=0", k, dev_rw_b); end
            end
            dev_ack_b = (k == 4);
        end
        checks++; if (dev_wr_data_b !== 32'h0) begin failures++; $display("[TB] FAIL wr_data_clear got=%h exp=0", dev_wr_data_b); end
    endtask

    task automatic test_stray_strobe();
        logic exp_rdy;
        $display("[TB] test_stray_strobe");
        cs_a = 1'b0; as_ = 1'b0; rw = READ; addr = 30'h10;
        dev_ack_a = 1'b1; dev_rd_data = 32'h0BADF00D;
        for (int k = 1; k <= 7; k++) begin
            next_cycle();
            if (k == 1) begin addr = 30'h20; end
            if (k == 2) begin cs_a = 1'b1; as_ = 1'b1; end
            exp_rdy = (k == 4) ? ENABLE_ : DISABLE_;
            checks++; if (rdy_a !== exp_rdy) begin failures++; $display("[TB] FAIL stray_rdy c%0d got=%b exp=%b", k, rdy_a, exp_rdy); end
            if (k == 2 || k == 3) begin
                checks++; if (dev_addr_a !== 30'h10) begin failures++; $display("[TB] FAIL stray_dev_addr c%0d got=%h exp=10", k, dev_addr_a); end
            end
            if (k == 4) begin
                checks++; if (rd_data_a !== 32'h0BADF00D) begin failures++; $display("[TB] FAIL stray_rd_data got=%h exp=0badf00d", rd_data_a); end
            end
        end
        dev_ack_a = 1'b0;
    endtask

    task automatic test_reset_in_dev();
        logic exp_rdy;
        $display("[TB] test_reset_in_dev");
        cs_a = 1'b0; as_ = 1'b0; rw = READ; addr = 30'h10; wr_data = 32'h55AA55AA; dev_ack_a = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            if (k == 1) begin cs_a = 1'b1; as_ = 1'b1; end
            if (k == 3) begin
                checks++; if (dev_req_a !== 1'b1) begin failures++; $display("[TB] FAIL rst_pre_dev_req got=%b exp=1", dev_req_a); end
                reset = 1'b1;
            end
            if (k == 4) begin
                checks++; if (dev_req_a !== 1'b0) begin failures++; $display("[TB] FAIL rst_dev_req got=%b exp=0", dev_req_a); end
                checks++; if (dev_addr_a !== 30'h0) begin failures++; $display("[TB] FAIL rst_dev_addr got=%h exp=0", dev_addr_a); end
                checks++; if (dev_wr_data_a !== 32'h0) begin failures++; $display("[TB] FAIL rst_dev_wr_data got=%h exp=0", dev_wr_data_a); end
                checks++; if (dev_rw_a !== READ) begin failures++; $display("[TB] FAIL rst_dev_rw got=%b exp=1", dev_rw_a); end
                reset = 1'b0;
            end
            if (k >= 4) begin
                checks++; if (rdy_a !== 1'b1) begin failures++; $display("[TB] FAIL rst_no_rdy c%0d got=%b exp=1", k, rdy_a); end
            end
        end
        cs_a = 1'b0; as_ = 1'b0; rw = READ; addr = 30'h7; dev_ack_a = 1'b1; dev_rd_data = 32'hCAFEF00D;
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            if (k == 1) begin cs_a = 1'b1; as_ = 1'b1; end
            exp_rdy = (k == 4) ? ENABLE_ : DISABLE_;
            checks++; if (rdy_a !== exp_rdy) begin failures++; $display("[TB] FAIL rst_after_rdy c%0d got=%b exp=%b", k, rdy_a, exp_rdy); end
            if (k == 4) begin
                checks++; if (rd_data_a !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL rst_after_rd_data got=%h exp=cafef00d", rd_data_a); end
            end
        end
        dev_ack_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic          exp_req, exp_rdy;
        logic [DW-1:0] exp_data;
        $display("[TB] test_back_to_back");
        cs_b = 1'b0; as_ = 1'b0; rw = READ; addr = 30'h1; dev_ack_b = 1'b1; dev_rd_data = 32'h11111111;
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            exp_req  = (k == 1) || (k == 4);
            exp_rdy  = ((k == 2) || (k == 5)) ? ENABLE_ : DISABLE_;
            exp_data = (k == 2) ? 32'h11111111 : ((k == 5) ? 32'h22222222 : 32'h0);
            checks++; if (dev_req_b !== exp_req) begin failures++; $display("[TB] FAIL b2b_dev_req c%0d got=%b exp=%b", k, dev_req_b, exp_req); end
            checks++; if (rdy_b !== exp_rdy) begin failures++; $display("[TB] FAIL b2b_rdy c%0d got=%b exp=%b", k, rdy_b, exp_rdy); end
            checks++; if (rd_data_b !== exp_data) begin failures++; $display("[TB] FAIL b2b_rd_data c%0d got=%h exp=%h", k, rd_data_b, exp_data); end
            if (k == 4) begin
                checks++; if (dev_addr_b !== 30'h2) begin failures++; $display("[TB] FAIL b2b_dev_addr got=%h exp=2", dev_addr_b); end
            end
            if (k == 1) begin cs_b = 1'b1; as_ = 1'b1; end
            if (k == 3) begin cs_b = 1'b0; as_ = 1'b0; addr = 30'h2; dev_rd_data = 32'h22222222; end
            if (k == 4) begin cs_b = 1'b1; as_ = 1'b1; end
        end
        dev_ack_b = 1'b0;
    endtask

`ifdef BUS_SLAVE_TIMEOUT_EN
    task automatic test_timeout();
        logic exp_req, exp_rdy, exp_err;
        $display("[TB] test_timeout");
        cs_a = 1'b0; as_ = 1'b0; rw = READ; addr = 30'h10; dev_ack_a = 1'b0; dev_rd_data = 32'hFFFFFFFF;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            if (k == 1) begin cs_a = 1'b1; as_ = 1'b1; end
            exp_req = (k >= 3) && (k <= 6);
            exp_rdy = (k == 7) ? ENABLE_ : DISABLE_;
            exp_err = (k == 7);
            checks++; if (dev_req_a !== exp_req) begin failures++; $display("[TB] FAIL to_dev_req c%0d got=%b exp=%b", k, dev_req_a, exp_req); end
            checks++; if (rdy_a !== exp_rdy) begin failures++; $display("[TB] FAIL to_rdy c%0d got=%b exp=%b", k, rdy_a, exp_rdy); end
            checks++; if (err_a !== exp_err) begin failures++; $display("[TB] FAIL to_err c%0d got=%b exp=%b", k, err_a, exp_err); end
            checks++; if (rd_data_a !== 32'h0) begin failures++; $display("[TB] FAIL to_rd_data c%0d got=%h exp=0", k, rd_data_a); end
        end
    endtask
`else
    task automatic test_timeout();
        $display("[TB] test_no_timeout");
        cs_a = 1'b0; as_ = 1'b0; rw = READ; addr = 30'h10; dev_ack_a = 1'b0; dev_rd_data = 32'hFFFFFFFF;
        for (int k = 1; k <= 13; k++) begin
            next_cycle();
            if (k == 1) begin cs_a = 1'b1; as_ = 1'b1; end
            if (k >= 3 && k <= 12) begin
                checks++; if (dev_req_a !== 1'b1) begin failures++; $display("[TB] FAIL noto_dev_req c%0d got=%b exp=1", k, dev_req_a); end
                checks++; if (rdy_a !== 1'b1) begin failures++; $display("[TB] FAIL noto_rdy c%0d got=%b exp=1", k, rdy_a); end
            end
            if (k == 13) begin
                checks++; if (rdy_a !== 1'b0) begin failures++; $display("[TB] FAIL noto_final_rdy got=%b exp=0", rdy_a); end
                checks++; if (rd_data_a !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL noto_rd_data got=%h exp=ffffffff", rd_data_a); end
            end
            checks++; if (err_a !== 1'b0) begin failures++; $display("[TB] FAIL noto_err c%0d got=%b exp=0", k, err_a); end
            dev_ack_a = (k == 12);
        end
        dev_ack_a = 1'b0;
        next_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_read_wait2();
        test_write_wait0();
        test_stray_strobe();
        test_reset_in_dev();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_slave_if.md
Name: bus_slave_if

Overview:
- Bus-side responder that sits between the shared system bus and one slave device (ROM, timer, UART, GPIO wrapper).
- Answers master accesses: qualifies the chip select with the address strobe, latches the request, and inserts programmable wait states.
- Runs a request/acknowledge handshake with the device backend, then returns one-cycle ready plus read data on the bus.
- Drives zero read data when not selected, so slave outputs can be OR-combined at the bus read mux.

Parameters:
ADDR_W, 30, word address width (matches bus word address)
DATA_W, 32, data width
WAIT_CYCLES, 1, fixed wait states inserted before device request (0..15)
TIMEOUT, 255, device-ack timeout in cycles (used only with optional feature; 1..255)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
cs_  in  1  chip select from address decoder, active-low
as_  in  1  address strobe from granted master, active-low, one-cycle pulse
rw  in  1  1=READ, 0=WRITE
addr  in  ADDR_W  word address
wr_data  in  DATA_W  write data
rd_data  out  DATA_W  read data, valid only while rdy_ low, else 0
rdy_  out  1  ready, active-low, one-cycle pulse
dev_req  out  1  device request, held high until dev_ack
dev_rw  out  1  latched rw
dev_addr  out  ADDR_W  latched addr
dev_wr_data  out  DATA_W  latched wr_data
dev_rd_data  in  DATA_W  device read data, valid with dev_ack
dev_ack  in  1  device acknowledge, sampled at clk edge
err  out  1  timeout pulse (optional feature only; tied 0 otherwise)

Behaviour:
- Reset: state IDLE; rdy_=1; rd_data=0; dev_req=0; dev_rw=READ; dev_addr=0; dev_wr_data=0; rd_buf=0; wait counter=0; err=0. Reset mid-transaction aborts silently with no rdy_ pulse, and dev_req drops the next cycle.
- States: IDLE, WAIT, DEV, READY.
- IDLE: when cs_=0 and as_=0 at an edge, latch addr/rw/wr_data into dev_* registers.
  - WAIT_CYCLES>0: load counter=WAIT_CYCLES and go to WAIT.
  - WAIT_CYCLES=0: go to DEV.
  - as_=0 with cs_=1 is ignored.
- WAIT: decrement the counter each edge; when counter=1, go to DEV. WAIT lasts exactly WAIT_CYCLES cycles.
- DEV: dev_req=1. On an edge with dev_ack=1:
  - capture dev_rd_data into rd_buf if dev_rw=READ;
  - go to READY.
- READY: one cycle only.
  - rdy_=0.
  - rd_data=rd_buf if dev_rw=READ, else 0.
  - Next state IDLE.
  - dev_* registers return to reset values on exit.
- Latency: call the as_ cycle 0 and let d = dev_ack delay in cycles (0 means ack in the first DEV cycle). rdy_ is low in cycle WAIT_CYCLES+d+2.
- New as_ while not IDLE: protocol violation; ignored with no state change. Back-to-back accesses are accepted in IDLE starting the cycle after READY.
- rdy_ and rd_data decode from the state register and rd_buf only; there is no combinational path from bus inputs.

Optional Feature:
- Macro: BUS_SLAVE_TIMEOUT_EN.
- Defined: a counter loads TIMEOUT on entry to DEV and decrements each DEV cycle without dev_ack. On reaching 0:
  - dev_req drops;
  - go to READY with rd_data forced to 0;
  - err=1 for that READY cycle.
  - dev_ack arriving in the same cycle as expiry wins: normal completion, err=0.
- Undefined: no timeout logic; DEV waits for dev_ack indefinitely; err tied 0.

Decomposition:
- Shared bus header/package holds:
  - READ/WRITE and ENABLE_/DISABLE_ constants;
  - WordAddrBus/WordDataBus widths;
  - BusSlvStateBus and BUS_SLV_STATE_IDLE/WAIT/DEV/READY encodings.
- One sub-module is natural: bus_slv_downcnt, a loadable 8-bit down-counter with a zero flag, instanced for wait states and (under the macro) for timeout.

Test Plan:
- Read, WAIT_CYCLES=2: cs_=0, as_=0 in cycle 0 with addr=0x10, rw=READ; dev_ack=1 immediately with dev_rd_data=0xDEADBEEF -> dev_req high in cycle 3, rdy_=0 and rd_data=0xDEADBEEF in cycle 4 only, rd_data=0 in cycle 5.
- Write, WAIT_CYCLES=0: addr=0x3, wr_data=0x12345678; dev_ack delayed 3 cycles -> dev_wr_data=0x12345678 while dev_req high; rdy_=0 in cycle 5; rd_data=0 throughout.
- Deselect: as_=0 with cs_=1 -> no dev_req, rdy_ stays 1, state IDLE.
- Stray strobe: second as_ during WAIT with addr=0x20 -> ignored; dev_addr keeps 0x10; exactly one rdy_ pulse.
- Reset in DEV: assert reset while dev_req=1 -> next cycle dev_req=0, rdy_=1, all dev_* regs 0; a following normal read completes correctly.
- Timeout (BUS_SLAVE_TIMEOUT_EN, TIMEOUT=4): dev_ack never asserted -> READY after 4 DEV cycles with rdy_=0, rd_data=0, err=1 for one cycle.
